// File: rtl/mux_arb_n.sv
// N-channel registered multiplexer with valid/ready handshake, external one-hot or round-robin grant.
// Optional packet lock in round-robin mode when MUX_ARB_LOCK_EN is defined.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 6,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mode,
  input  logic [N_CH-1:0]         sel,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N_CH-1:0]         in_last,
`endif
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  logic [WIDTH-1:0] ch_data [N_CH];
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [CH_W-1:0]  out_ch_reg, out_ch_next;
  logic             out_valid_reg, out_valid_next;
  logic             sel_err_reg, sel_err_next;
  logic [CH_W-1:0]  rr_ptr_reg, rr_ptr_next;

  logic             slot_free;
  logic             sel_zero, sel_onehot, sel_multi;
  logic [N_CH-1:0]  ext_grant;
  logic [N_CH-1:0]  rr_grant;
  logic [N_CH-1:0]  arb_grant;
  logic [N_CH-1:0]  grant;
  logic [CH_W-1:0]  grant_idx;
  logic             xfer;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign slot_free  = !out_valid_reg || out_ready;
  assign sel_zero   = (sel == '0);
  assign sel_onehot = !sel_zero && ((sel & (sel - 1'b1)) == '0);
  assign sel_multi  = !sel_zero && !sel_onehot;
  assign ext_grant  = sel_onehot ? (sel & in_valid) : '0;

  // Rotating priority: first valid channel strictly after rr_ptr, with wrap.
  always_comb begin
    int unsigned idx;
    logic        found;
    rr_grant = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(rr_ptr_reg) + k) % N_CH;
      if (!found && in_valid[idx]) begin
        found         = 1'b1;
        rr_grant[idx] = 1'b1;
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  logic            lock_reg, lock_next;
  logic [CH_W-1:0] lock_ch_reg, lock_ch_next;
  logic [N_CH-1:0] lock_grant;

  // A locked packet owns the grant even while its source idles.
  always_comb begin
    lock_grant = '0;
    lock_grant[lock_ch_reg] = in_valid[lock_ch_reg];
  end

  assign arb_grant = lock_reg ? lock_grant : rr_grant;
`else
  assign arb_grant = rr_grant;
`endif

  assign grant = mode ? arb_grant : ext_grant;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) grant_idx = CH_W'(i);
    end
  end

  assign xfer     = slot_free && (grant != '0);
  assign in_ready = grant & {N_CH{slot_free}};

  always_comb begin
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    out_valid_next = out_valid_reg;
    if (xfer) begin
      out_data_next  = ch_data[grant_idx];
      out_ch_next    = grant_idx;
      out_valid_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // Set has priority over clear; traffic never touches the flag.
  always_comb begin
    sel_err_next = sel_err_reg;
    if (!mode && sel_multi) begin
      sel_err_next = 1'b1;
    end else if (err_clr) begin
      sel_err_next = 1'b0;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  always_comb begin
    rr_ptr_next  = rr_ptr_reg;
    lock_next    = lock_reg;
    lock_ch_next = lock_ch_reg;
    if (xfer && mode) begin
      if (in_last[grant_idx]) begin
        lock_next   = 1'b0;
        rr_ptr_next = grant_idx;
      end else begin
        lock_next    = 1'b1;
        lock_ch_next = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_reg    <= 1'b0;
      lock_ch_reg <= '0;
    end else begin
      lock_reg    <= lock_next;
      lock_ch_reg <= lock_ch_next;
    end
  end
`else
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (xfer && mode) rr_ptr_next = grant_idx;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      sel_err_reg   <= 1'b0;
      rr_ptr_reg    <= CH_W'(N_CH - 1);
    end else begin
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      out_valid_reg <= out_valid_next;
      sel_err_reg   <= sel_err_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed self-checking bench for mux_arb_n (N_CH=6, WIDTH=32); packet-lock vectors run when MUX_ARB_LOCK_EN is defined.
module tb_mux_arb_n;
  localparam int WIDTH = 32;
  localparam int N_CH  = 6;
  localparam int CH_W  = 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  mode;
  logic [N_CH-1:0]       sel;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;
  logic                  err_clr;
`ifdef MUX_ARB_LOCK_EN
  logic [N_CH-1:0]       in_last;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mux_arb_n #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef MUX_ARB_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    reset_n   = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    in_last   = '1;
`endif
    for (int i = 0; i < N_CH; i++) set_ch(i, 32'hC0DE_0000 + 32'(i));

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_ch",    64'(out_ch),    64'd0);
    check("rst_sel_err",   64'(sel_err),   64'd0);
    tick(); tick();
    reset_n = 1'b1;

    // Round robin, all valid: ch0..ch5 then ch0, no bubbles
    mode     = 1'b1;
    in_valid = 6'b111111;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("rr_ready_%0d", k), 64'(in_ready), 64'(6'b1 << (k % 6)));
      tick();
      check($sformatf("rr_valid_%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("rr_ch_%0d", k),    64'(out_ch),    64'(k % 6));
      check($sformatf("rr_data_%0d", k),  64'(out_data),  64'(32'hC0DE_0000 + 32'(k % 6)));
    end
    in_valid = '0;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_hold",  64'(out_data),  64'h0000_0000_C0DE_0000);

    // Wrap-around: rr_ptr=0, ch5 before ch0
    in_valid = 6'b100001;
    @(negedge clk);
    check("wrap_ready_5", 64'(in_ready), 64'(6'b100000));
    tick();
    check("wrap_ch_5", 64'(out_ch), 64'd5);
    @(negedge clk);
    check("wrap_ready_0", 64'(in_ready), 64'(6'b000001));
    tick();
    check("wrap_ch_0", 64'(out_ch), 64'd0);
    in_valid = '0;
    tick();

    // External one-hot select
    mode = 1'b0;
    set_ch(2, 32'hA5A5_0002);
    sel      = 6'b000100;
    in_valid = 6'b000100;
    @(negedge clk);
    check("ext_ready", 64'(in_ready), 64'(6'b000100));
    tick();
    check("ext_data",  64'(out_data),  64'h0000_0000_A5A5_0002);
    check("ext_ch",    64'(out_ch),    64'd2);
    check("ext_valid", 64'(out_valid), 64'd1);
    sel = 6'b000001;
    @(negedge clk);
    check("ext_sel_not_valid", 64'(in_ready), 64'd0);
    in_valid = '0;
    tick();

    // Multi-hot select
    sel      = 6'b000110;
    in_valid = 6'b000110;
    @(negedge clk);
    check("multi_ready", 64'(in_ready), 64'd0);
    tick();
    check("multi_valid", 64'(out_valid), 64'd0);
    check("multi_err",   64'(sel_err),   64'd1);
    sel      = '0;
    in_valid = '0;
    tick();
    check("err_sticky", 64'(sel_err), 64'd1);
    sel     = 6'b000110;
    err_clr = 1'b1;
    tick();
    check("err_set_wins", 64'(sel_err), 64'd1);
    sel = 6'b000001;
    tick();
    check("err_cleared", 64'(sel_err), 64'd0);
    err_clr = 1'b0;
    mode    = 1'b1;
    sel     = 6'b000110;
    tick();
    check("err_rr_ignored", 64'(sel_err), 64'd0);

    // Back-pressure then simultaneous drain/load
    mode = 1'b0;
    sel  = 6'b000001;
    set_ch(0, 32'hD000_0000);
    in_valid = 6'b000001;
    tick();
    check("bp_load", 64'(out_data), 64'h0000_0000_D000_0000);
    out_ready = 1'b0;
    set_ch(0, 32'hD000_0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_ready_%0d", k), 64'(in_ready), 64'd0);
      tick();
      check($sformatf("bp_data_%0d", k), 64'(out_data), 64'h0000_0000_D000_0000);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'(6'b000001));
    tick();
    check("bp_release_valid", 64'(out_valid), 64'd1);
    check("bp_release_data",  64'(out_data),  64'h0000_0000_D000_0001);
    in_valid = '0;
    tick();

    // Mode-0 traffic left rr_ptr at 0, so round robin resumes at ch1
    mode     = 1'b1;
    sel      = '0;
    in_valid = 6'b111111;
    @(negedge clk);
    check("rr_ptr_kept", 64'(in_ready), 64'(6'b000010));
    tick();
    check("rr_ptr_kept_ch", 64'(out_ch), 64'd1);
    in_valid = '0;
    tick();

`ifdef MUX_ARB_LOCK_EN
    // Packet lock: ch1 sends 3 words while ch0/ch2 compete
    in_valid = 6'b000001;
    tick();
    check("lk_pre_ch", 64'(out_ch), 64'd0);
    in_valid = 6'b000111;
    in_last  = 6'b111101;
    @(negedge clk);
    check("lk_w1_ready", 64'(in_ready), 64'(6'b000010));
    tick();
    check("lk_w1_ch", 64'(out_ch), 64'd1);
    in_valid = 6'b000101;
    @(negedge clk);
    check("lk_idle_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 6'b000111;
    @(negedge clk);
    check("lk_w2_ready", 64'(in_ready), 64'(6'b000010));
    tick();
    check("lk_w2_ch", 64'(out_ch), 64'd1);
    in_last = 6'b111111;
    @(negedge clk);
    check("lk_w3_ready", 64'(in_ready), 64'(6'b000010));
    tick();
    check("lk_w3_ch", 64'(out_ch), 64'd1);
    @(negedge clk);
    check("lk_next_ready", 64'(in_ready), 64'(6'b000100));
    tick();
    check("lk_next_ch", 64'(out_ch), 64'd2);
    in_valid = '0;
    tick();
`endif

    // Asynchronous reset with a word held
    in_valid = 6'b001000;
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data",  64'(out_data),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
